// File: rtl/pht_sched.sv
// pht_sched: pattern-history-table scheduler sharing one array port between fetch lookups and buffered execute updates
//   clk, rst        clock, asynchronous active-high reset
//   pred_req/idx    fetch lookup request; pred_stall holds it off when the update FIFO is full
//   pred_valid/taken registered lookup result, one cycle after the grant
//   upd_valid/idx/taken, upd_ready  resolved-branch update handshake into the FIFO
//   q_count         current FIFO occupancy
module pht_sched #(
    parameter int IDX_WIDTH = 6,
    parameter int QDEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_req,
    input  logic [IDX_WIDTH-1:0]       pred_idx,
    output logic                       pred_stall,
    output logic                       pred_valid,
    output logic                       pred_taken,
    input  logic                       upd_valid,
    input  logic [IDX_WIDTH-1:0]       upd_idx,
    input  logic                       upd_taken,
    output logic                       upd_ready,
    output logic [$clog2(QDEPTH):0]    q_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int N  = 2 ** IDX_WIDTH;

    logic [1:0]           r_ctr [N];
    logic [IDX_WIDTH-1:0] r_q_idx [QDEPTH];
    logic [QDEPTH-1:0]    r_q_tk;
    logic [PW-1:0]        r_head, r_tail;
    logic [CW-1:0]        r_count;

    logic                 w_full, w_lookup, w_drain, w_push, w_dtk;
    logic [IDX_WIDTH-1:0] w_didx;
    logic [1:0]           w_cur, w_next;

    assign w_full     = r_count == CW'(QDEPTH);
    assign w_lookup   = pred_req && !w_full;
    // A full FIFO takes the port so fetch cannot starve updates forever
    assign w_drain    = (r_count != '0) && !w_lookup;
    assign w_push     = upd_valid && !w_full;
    assign pred_stall = pred_req && w_full;
    assign upd_ready  = !w_full;
    assign q_count    = r_count;

    assign w_didx = r_q_idx[r_head];
    assign w_dtk  = r_q_tk[r_head];
    assign w_cur  = r_ctr[w_didx];
    assign w_next = w_dtk ? (w_cur == 2'b11 ? w_cur : w_cur + 2'd1)
                          : (w_cur == 2'b00 ? w_cur : w_cur - 2'd1);

    // Storage needs no reset: occupancy and pointers define what is live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_tail] <= upd_idx;
            r_q_tk[r_tail]  <= upd_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_ctr[i] <= 2'b01;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= w_lookup;
            pred_taken <= w_lookup ? r_ctr[pred_idx][1] : 1'b0;
            if (w_drain) begin
                r_ctr[w_didx] <= w_next;
                r_head        <= r_head + 1'b1;
            end
            if (w_push) r_tail <= r_tail + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_drain);
        end
    end
endmodule

// File: tb/tb_pht_sched.sv
// tb_pht_sched: scoreboard bench for pht_sched with a cycle-level reference model of the FIFO and counter array
module tb_pht_sched;
    logic       clk = 1'b0, rst = 1'b1;
    logic       pred_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [5:0] pred_idx = '0, upd_idx = '0;
    logic       pred_stall, pred_valid, pred_taken, upd_ready;
    logic [2:0] q_count;

    pht_sched #(.IDX_WIDTH(6), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_idx(pred_idx), .pred_stall(pred_stall),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [5:0] idx; logic t;} upd_t;
    logic [1:0] m_ctr [64];
    upd_t       mq[$];
    logic       exp_q[$];
    int         n_chk = 0, n_err = 0, n_stall = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        return t ? (c == 2'b11 ? c : c + 2'd1) : (c == 2'b00 ? c : c - 2'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 2'b01;
        mq.delete();
        exp_q.delete();
    endtask

    // One clock cycle, entered and left just after a falling edge
    task automatic cyc(input logic req, input logic [5:0] pidx, input logic uv, input logic [5:0] uidx, input logic ut);
        logic full, grant, drain, push;
        upd_t e;
        pred_req = req; pred_idx = pidx; upd_valid = uv; upd_idx = uidx; upd_taken = ut;
        #1;
        full  = mq.size() == 4;
        grant = req && !full;
        drain = mq.size() != 0 && !grant;
        push  = uv && !full;
        check("stall", 8'(pred_stall), 8'(req && full));
        check("ready", 8'(upd_ready), 8'(!full));
        check("q_count", 8'(q_count), 8'(mq.size()));
        if (pred_stall) n_stall++;
        if (grant) exp_q.push_back(m_ctr[pidx][1]);
        @(posedge clk);
        if (drain) begin
            e = mq.pop_front();
            m_ctr[e.idx] = sat(m_ctr[e.idx], e.t);
        end
        if (push) begin
            e.idx = uidx; e.t = ut;
            mq.push_back(e);
        end
        #1;
        if (exp_q.size() != 0) begin
            check("pred_valid", 8'(pred_valid), 8'd1);
            check("pred_taken", 8'(pred_taken), 8'(exp_q.pop_front()));
        end else begin
            check("pred_valid_idle", 8'(pred_valid), 8'd0);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic lookup(input string tag, input logic [5:0] idx, input logic exp);
        cyc(1'b1, idx, 1'b0, 6'd0, 1'b0);
        check(tag, 8'(pred_taken), 8'(exp));
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        pred_req = 1'b0; upd_valid = 1'b0;
        #1;
        check("rst_q_count", 8'(q_count), 8'd0);
        check("rst_ready", 8'(upd_ready), 8'd1);
        check("rst_pred_valid", 8'(pred_valid), 8'd0);
        check("rst_pred_taken", 8'(pred_taken), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // post-reset lookups
        lookup("reset_idx5", 6'd5, 1'b0);
        lookup("reset_idx0", 6'd0, 1'b0);
        lookup("reset_idx63", 6'd63, 1'b0);

        // saturation on idx 3
        for (int i = 0; i < 4; i++) begin cyc(1'b0, 6'd0, 1'b1, 6'd3, 1'b1); idle(1); end
        lookup("sat_up", 6'd3, 1'b1);
        cyc(1'b0, 6'd0, 1'b1, 6'd3, 1'b1); idle(2);
        lookup("sat_up_hold", 6'd3, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 1'b1, 6'd3, 1'b0);
        idle(2);
        lookup("sat_down", 6'd3, 1'b0);
        cyc(1'b0, 6'd0, 1'b1, 6'd3, 1'b0); idle(2);
        lookup("sat_down_hold", 6'd3, 1'b0);

        // starvation then a single stall cycle
        n_stall = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 6'd20, 1'b1, 6'(30 + i), 1'b1);
        check("starve_full", 8'(q_count), 8'd4);
        for (int i = 0; i < 4; i++) cyc(1'b1, 6'd20, 1'b0, 6'd0, 1'b0);
        check("stall_once", 8'(n_stall), 8'd1);
        check("after_stall_q", 8'(q_count), 8'd3);
        idle(4);
        for (int i = 0; i < 4; i++) lookup("starve_applied", 6'(30 + i), 1'b1);

        // push/pop overlap with pointer wrap
        cyc(1'b1, 6'd1, 1'b1, 6'd10, 1'b1);
        cyc(1'b1, 6'd1, 1'b1, 6'd11, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 6'd0, 1'b1, 6'(10 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            check("overlap_q", 8'(q_count), 8'd2);
        end
        idle(3);
        for (int i = 10; i < 14; i++) cyc(1'b1, 6'(i), 1'b0, 6'd0, 1'b0);

        // same-index ordering from reset
        do_reset();
        cyc(1'b0, 6'd0, 1'b1, 6'd7, 1'b1);
        cyc(1'b0, 6'd0, 1'b1, 6'd7, 1'b1);
        cyc(1'b0, 6'd0, 1'b1, 6'd7, 1'b0);
        idle(1);
        lookup("order_idx7", 6'd7, 1'b1);

        // reset mid-operation
        cyc(1'b0, 6'd0, 1'b1, 6'd9, 1'b1);
        cyc(1'b0, 6'd0, 1'b1, 6'd9, 1'b1);
        idle(2);
        lookup("pre_rst_idx9", 6'd9, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'd0, 1'b1, 6'd9, 1'b0);
        check("pre_rst_q", 8'(q_count), 8'd3);
        do_reset();
        idle(2);
        lookup("post_rst_idx9", 6'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
